// File: rtl/vend_pkg.sv
// Shared vending definitions: coin codes, coin values,
// change-dispenser state encoding and default width.
package vend_pkg;

  localparam int W_DEF = 8;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_5    = 2'b10;
  localparam logic [1:0] COIN_10   = 2'b11;

  localparam int VAL_1  = 1;
  localparam int VAL_5  = 5;
  localparam int VAL_10 = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    ISSUE  = 3'd2,
    FINISH = 3'd3,
    FAULT  = 3'd4
  } cd_state_e;

  function automatic logic [3:0] coin_value(
    input logic [1:0] c
  );
    logic [3:0] v;
    v = 4'd0;
    unique case (c)
      COIN_1:  v = 4'd1;
      COIN_5:  v = 4'd5;
      COIN_10: v = 4'd10;
      default: v = 4'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/coin_select.sv
// Greedy coin picker: largest usable coin not above rem.
// usable[0]=1-unit, [1]=5-unit, [2]=10-unit.
module coin_select
  import vend_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] rem,
  input  logic [2:0]   usable,
  output logic [1:0]   coin,
  output logic         found
);

  logic use10;
  logic use5;
  logic use1;

  assign use10 = usable[2] && (rem >= W'(VAL_10));
  assign use5  = !use10 && usable[1]
               && (rem >= W'(VAL_5));
  assign use1  = !use10 && !use5 && usable[0]
               && (rem >= W'(VAL_1));

  always_comb begin
    coin  = COIN_NONE;
    found = 1'b0;
    unique case (1'b1)
      use10: begin
        coin  = COIN_10;
        found = 1'b1;
      end
      use5: begin
        coin  = COIN_5;
        found = 1'b1;
      end
      use1: begin
        coin  = COIN_1;
        found = 1'b1;
      end
      default: begin
        coin  = COIN_NONE;
        found = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays CREDIT-PRICE out one coin at a time.
// CHANGE_INVENTORY_EN adds the EMPTY port and empty-hopper faults.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         REQ,
  input  logic [W-1:0] CREDIT,
  input  logic [W-1:0] PRICE,
  input  logic         COIN_ACK,
`ifdef CHANGE_INVENTORY_EN
  input  logic [2:0]   EMPTY,
`endif
  output logic [1:0]   COIN,
  output logic         COIN_VLD,
  output logic         BUSY,
  output logic         DONE,
  output logic         ERR
);

  cd_state_e    state_q;
  cd_state_e    state_d;
  logic [W-1:0] rem_q;
  logic [1:0]   coin_q;
  logic [2:0]   usable;
  logic [1:0]   pick;
  logic         found;
  logic         short;

`ifdef CHANGE_INVENTORY_EN
  assign usable = ~EMPTY;
`else
  assign usable = 3'b111;
`endif

  assign short = CREDIT < PRICE;

  coin_select #(.W(W)) u_sel (
    .rem    (rem_q),
    .usable (usable),
    .coin   (pick),
    .found  (found)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (REQ) begin
          state_d = short ? FAULT : SELECT;
        end
      end
      SELECT: begin
        if (rem_q == '0) begin
          state_d = FINISH;
        end else if (found) begin
          state_d = ISSUE;
        end else begin
          state_d = FAULT;
        end
      end
      ISSUE: begin
        if (COIN_ACK) begin
          state_d = SELECT;
        end
      end
      FINISH:  state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      rem_q   <= '0;
      coin_q  <= COIN_NONE;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && REQ && !short) begin
        rem_q <= CREDIT - PRICE;
      end
      if (state_q == SELECT && rem_q != '0 && found) begin
        coin_q <= pick;
      end
      // Clearing on ack keeps COIN at 00 outside ISSUE.
      if (state_q == ISSUE && COIN_ACK) begin
        rem_q  <= rem_q - W'(coin_value(coin_q));
        coin_q <= COIN_NONE;
      end
    end
  end

  assign COIN     = coin_q;
  assign COIN_VLD = (state_q == ISSUE);
  assign BUSY     = (state_q != IDLE);
  assign DONE     = (state_q == FINISH);
  assign ERR      = (state_q == FAULT);

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser.
// Define CHANGE_INVENTORY_EN to cover the EMPTY port.
module tb_change_dispenser;

  logic       CLK;
  logic       RST;
  logic       REQ;
  logic [7:0] CREDIT;
  logic [7:0] PRICE;
  logic       COIN_ACK;
`ifdef CHANGE_INVENTORY_EN
  logic [2:0] EMPTY;
`endif
  logic [1:0] COIN;
  logic       COIN_VLD;
  logic       BUSY;
  logic       DONE;
  logic       ERR;

  int errors;
  int checks;
  int coins[$];
  int vcyc[$];
  int exp_q[$];
  int done_cyc;
  int err_cyc;
  int vld_cnt;
  int idle_bad;
  int hold_bad;
  logic busy_log[0:31];

  change_dispenser #(.W(8)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .REQ      (REQ),
    .CREDIT   (CREDIT),
    .PRICE    (PRICE),
    .COIN_ACK (COIN_ACK),
`ifdef CHANGE_INVENTORY_EN
    .EMPTY    (EMPTY),
`endif
    .COIN     (COIN),
    .COIN_VLD (COIN_VLD),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .ERR      (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic chk_seq(input string tag,
                         input int got[$]);
    chk({tag, " len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      chk(tag, (i < got.size()) ? got[i] : -1,
          exp_q[i]);
    end
  endtask

  // Cycle n is the cycle after the edge that samples REQ
  // plus n-1; the hopper acks after dly extra VLD cycles.
  task automatic run(input logic [7:0] cr,
                     input logic [7:0] pr,
                     input int dly,
                     input int ncyc,
                     input int req_cyc);
    int wcnt;
    logic pv;
    logic [1:0] pc;
    coins.delete();
    vcyc.delete();
    done_cyc = -1;
    err_cyc  = -1;
    vld_cnt  = 0;
    idle_bad = 0;
    hold_bad = 0;
    wcnt = 0;
    pv = 1'b0;
    pc = 2'b00;
    for (int i = 0; i < 32; i++) busy_log[i] = 1'b0;
    CREDIT = cr;
    PRICE  = pr;
    REQ    = 1'b1;
    step();
    REQ    = 1'b0;
    CREDIT = 8'd0;
    PRICE  = 8'd0;
    for (int c = 1; c <= ncyc; c++) begin
      busy_log[c] = BUSY;
      if (DONE && done_cyc < 0) done_cyc = c;
      if (ERR && err_cyc < 0) err_cyc = c;
      if (!COIN_VLD && COIN !== 2'b00) idle_bad = 1;
      if (COIN_VLD) begin
        vld_cnt++;
        if (!pv) begin
          coins.push_back(int'(COIN));
          vcyc.push_back(c);
        end else if (COIN !== pc) begin
          hold_bad = 1;
        end
      end
      if (COIN_VLD && wcnt == dly) begin
        COIN_ACK = 1'b1;
        wcnt = 0;
      end else begin
        COIN_ACK = 1'b0;
        if (COIN_VLD) wcnt++;
      end
      REQ = (c == req_cyc);
      if (c == req_cyc) begin
        CREDIT = 8'd99;
        PRICE  = 8'd1;
      end
      pv = COIN_VLD;
      pc = COIN;
      if (c < ncyc) step();
    end
    COIN_ACK = 1'b0;
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    RST      = 1'b0;
    REQ      = 1'b0;
    CREDIT   = 8'd0;
    PRICE    = 8'd0;
    COIN_ACK = 1'b0;
`ifdef CHANGE_INVENTORY_EN
    EMPTY    = 3'b000;
`endif
    #1;
    chk("rst coin", int'(COIN), 0);
    chk("rst vld", int'(COIN_VLD), 0);
    chk("rst busy", int'(BUSY), 0);
    chk("rst done", int'(DONE), 0);
    chk("rst err", int'(ERR), 0);
    step();
    step();
    RST = 1'b1;
    step();

    run(8'd25, 8'd8, 0, 11, 0);
    exp_q = '{3, 2, 1, 1};
    chk_seq("t1 coins", coins);
    exp_q = '{2, 4, 6, 8};
    chk_seq("t1 vld cycles", vcyc);
    chk("t1 vld count", vld_cnt, 4);
    chk("t1 done cycle", done_cyc, 10);
    chk("t1 err", err_cyc, -1);
    chk("t1 idle coin", idle_bad, 0);
    chk("t1 busy c11", int'(busy_log[11]), 0);

    run(8'd5, 8'd7, 0, 3, 0);
    chk("t2 err cycle", err_cyc, 1);
    chk("t2 vld count", vld_cnt, 0);
    chk("t2 busy c1", int'(busy_log[1]), 1);
    chk("t2 busy c2", int'(busy_log[2]), 0);
    chk("t2 done", done_cyc, -1);

    run(8'd40, 8'd40, 0, 3, 0);
    chk("t3 done cycle", done_cyc, 2);
    chk("t3 vld count", vld_cnt, 0);
    chk("t3 busy c3", int'(busy_log[3]), 0);
    run(8'd12, 8'd5, 0, 9, 0);
    exp_q = '{2, 1, 1};
    chk_seq("t3 second coins", coins);
    chk("t3 second done", done_cyc, 8);

    run(8'd10, 8'd0, 5, 10, 4);
    exp_q = '{3};
    chk_seq("t4 coins", coins);
    chk("t4 vld count", vld_cnt, 6);
    chk("t4 hold", hold_bad, 0);
    chk("t4 done cycle", done_cyc, 9);
    chk("t4 busy c10", int'(busy_log[10]), 0);
    REQ = 1'b0;
    step();
    chk("t4 req ignored", int'(BUSY), 0);

    run(8'd30, 8'd0, 0, 3, 0);
    step();
    chk("t5 vld c4", int'(COIN_VLD), 1);
    chk("t5 coin c4", int'(COIN), 3);
    #2;
    RST = 1'b0;
    #1;
    chk("t5 rst vld", int'(COIN_VLD), 0);
    chk("t5 rst coin", int'(COIN), 0);
    chk("t5 rst busy", int'(BUSY), 0);
    step();
    chk("t5 no done", int'(DONE), 0);
    RST = 1'b1;
    step();
    chk("t5 idle done", int'(DONE), 0);
    run(8'd7, 8'd0, 0, 9, 0);
    exp_q = '{2, 1, 1};
    chk_seq("t5 fresh coins", coins);
    chk("t5 fresh done", done_cyc, 8);

`ifdef CHANGE_INVENTORY_EN
    EMPTY = 3'b100;
    run(8'd17, 8'd0, 0, 13, 0);
    exp_q = '{2, 2, 2, 1, 1};
    chk_seq("inv coins", coins);
    chk("inv done cycle", done_cyc, 12);
    chk("inv err", err_cyc, -1);
    EMPTY = 3'b001;
    run(8'd3, 8'd0, 0, 4, 0);
    chk("inv err cycle", err_cyc, 2);
    chk("inv vld count", vld_cnt, 0);
    chk("inv done", done_cyc, -1);
    EMPTY = 3'b000;
`endif

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
